perm_route_ctrl: RTL and testbench

//   Sequencer placed directly upstream of the 3x3 byte crossbar (three 3:1 muxes, 2-bit select per output).
//   - Drives the crossbar's 6-bit select and captures its outputs and valid flag.
//   - Default: walks the valid one-to-one routes (permutations) in a fixed order.
//   - Presents each captured result on a valid/ready output port.
//   - Flags any capture the crossbar reported as invalid.

---
 rtl/perm_route_ctrl.sv | 137 +++++++++++++
 tb/tb_perm_route_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perm_route_ctrl.sv
// perm_route_ctrl: walks the 3x3 crossbar through its permutations and captures each routed result.
// Define PERM_MANUAL_SEL_EN to honour mode/sel_in for a single manual route per run.
module perm_route_ctrl #(
   parameter int DW       = 8,
   parameter int NUM_PERM = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [5:0]    sel_in,
   input  logic [DW-1:0] mux_out0,
   input  logic [DW-1:0] mux_out1,
   input  logic [DW-1:0] mux_out2,
   input  logic          mux_valid,
   input  logic          out_ready,
   output logic [5:0]    select,
   output logic          busy,
   output logic          res_valid,
   output logic [DW-1:0] res0,
   output logic [DW-1:0] res1,
   output logic [DW-1:0] res2,
   output logic [2:0]    res_idx,
   output logic          res_bad,
   output logic          err,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
   localparam logic [2:0] LAST = 3'(NUM_PERM - 1);
   localparam logic [5:0] PARK = 6'h3F;
   if (NUM_PERM < 1 || NUM_PERM > 6) begin : g_bad_num_perm
      $error("perm_route_ctrl: NUM_PERM must be in 1..6");
   end
   function automatic logic [5:0] perm(input logic [2:0] i);
      return i == 3'd0 ? 6'h24 :
             i == 3'd1 ? 6'h18 :
             i == 3'd2 ? 6'h21 :
             i == 3'd3 ? 6'h09 :
             i == 3'd4 ? 6'h12 : 6'h06;
   endfunction
   logic man_sel;
`ifdef PERM_MANUAL_SEL_EN
   assign man_sel = mode;
`else
   logic unused_mode;
   assign man_sel     = 1'b0;
   assign unused_mode = mode;
`endif
   state_t          state, state_n;
   logic [2:0]      idx, idx_n, res_idx_n;
   logic            man, man_n;
   logic [5:0]      select_n;
   logic            res_valid_n, res_bad_n, err_n, done_n;
   logic [DW-1:0]   res0_n, res1_n, res2_n;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         select    <= PARK;
         idx       <= '0;
         man       <= 1'b0;
         res_valid <= 1'b0;
         res0      <= '0;
         res1      <= '0;
         res2      <= '0;
         res_idx   <= '0;
         res_bad   <= 1'b0;
         err       <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         select    <= select_n;
         idx       <= idx_n;
         man       <= man_n;
         res_valid <= res_valid_n;
         res0      <= res0_n;
         res1      <= res1_n;
         res2      <= res2_n;
         res_idx   <= res_idx_n;
         res_bad   <= res_bad_n;
         err       <= err_n;
         done      <= done_n;
      end
   end
   always_comb begin
      state_n     = state;
      select_n    = select;
      idx_n       = idx;
      man_n       = man;
      res_valid_n = res_valid;
      res0_n      = res0;
      res1_n      = res1;
      res2_n      = res2;
      res_idx_n   = res_idx;
      res_bad_n   = res_bad;
      err_n       = err;
      done_n      = 1'b0;
      case (state)
         IDLE: begin
            select_n = PARK;
            // done is high in the cycle right after a run ends; a start seen then is dropped
            if (start && !done) begin
               err_n    = 1'b0;
               idx_n    = '0;
               man_n    = man_sel;
               select_n = man_sel ? sel_in : perm(3'd0);
               state_n  = DRIVE;
            end
         end
         DRIVE: begin
            res0_n      = mux_out0;
            res1_n      = mux_out1;
            res2_n      = mux_out2;
            res_bad_n   = !mux_valid;
            err_n       = err | !mux_valid;
            res_valid_n = 1'b1;
            res_idx_n   = idx;
            state_n     = HOLD;
         end
         HOLD: begin
            if (res_valid && out_ready) begin
               res_valid_n = 1'b0;
               if (idx == LAST || man) begin
                  select_n = PARK;
                  done_n   = 1'b1;
                  state_n  = IDLE;
               end else begin
                  idx_n    = idx + 3'd1;
                  select_n = perm(idx + 3'd1);
                  state_n  = DRIVE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_perm_route_ctrl.sv
// tb_perm_route_ctrl: randomized scoreboard bench for perm_route_ctrl with a modelled 3x3 crossbar.
// Expectations follow PERM_MANUAL_SEL_EN the same way the design does.
module tb_perm_route_ctrl;
   logic       clk = 0, rst = 1, start = 0, start2 = 0, mode = 0, out_ready = 1;
   logic [5:0] sel_in = '0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] data;
      logic [2:0]  idx;
      logic        bad;
      logic [5:0]  sel;
   } exp_t;
   exp_t q1[$], q2[$];
   int   checks = 0, errors = 0, cyc = 0, s_cyc1 = 0, s_cyc2 = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xb_val(input logic [1:0] c);
      return c == 2'd3 ? 8'h00 : 8'(17 * (int'(c) + 1));
   endfunction
   function automatic logic has3(input logic [5:0] s);
      return s[1:0] == 2'd3 || s[3:2] == 2'd3 || s[5:4] == 2'd3;
   endfunction

   logic [5:0] sel1, sel2;
   logic [2:0] ri1, ri2;
   logic [7:0] r10, r11, r12, r20, r21, r22;
   logic       busy1, rv1, rb1, err1, done1, busy2, rv2, rb2, err2, done2;

   perm_route_ctrl #(.DW(8), .NUM_PERM(6)) dut1 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .sel_in(sel_in),
      .mux_out0(xb_val(sel1[1:0])), .mux_out1(xb_val(sel1[3:2])), .mux_out2(xb_val(sel1[5:4])),
      .mux_valid(!has3(sel1)), .out_ready(out_ready), .select(sel1), .busy(busy1),
      .res_valid(rv1), .res0(r10), .res1(r11), .res2(r12), .res_idx(ri1), .res_bad(rb1),
      .err(err1), .done(done1));

   perm_route_ctrl #(.DW(8), .NUM_PERM(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(1'b0), .sel_in(6'h00),
      .mux_out0(xb_val(sel2[1:0])), .mux_out1(xb_val(sel2[3:2])), .mux_out2(xb_val(sel2[5:4])),
      .mux_valid(!has3(sel2)), .out_ready(out_ready), .select(sel2), .busy(busy2),
      .res_valid(rv2), .res0(r20), .res1(r21), .res2(r22), .res_idx(ri2), .res_bad(rb2),
      .err(err2), .done(done2));

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Reference: one entry per permutation of {0,1,2} in lexicographic order, or one manual route
   function automatic void push_run(input bit which, input int n, input bit man, input logic [5:0] ms);
      exp_t e;
      int   k = 0;
      if (man) begin
         e.sel  = ms;
         e.data = {xb_val(ms[1:0]), xb_val(ms[3:2]), xb_val(ms[5:4])};
         e.idx  = 3'd0;
         e.bad  = has3(ms);
         if (which) q2.push_back(e); else q1.push_back(e);
         return;
      end
      for (int a = 0; a < 3; a++)
         for (int b = 0; b < 3; b++)
            for (int c = 0; c < 3; c++)
               if (a != b && a != c && b != c && k < n) begin
                  e.sel  = {2'(c), 2'(b), 2'(a)};
                  e.data = {xb_val(2'(a)), xb_val(2'(b)), xb_val(2'(c))};
                  e.idx  = 3'(k);
                  e.bad  = 1'b0;
                  if (which) q2.push_back(e); else q1.push_back(e);
                  k++;
               end
   endfunction

   always @(negedge clk) begin
      if (!rst && rv1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1 unexpected result idx=%0d", ri1);
         end else begin
            chk("dut1 data", 32'({r10, r11, r12}), 32'(q1[0].data));
            chk("dut1 idx", 32'(ri1), 32'(q1[0].idx));
            chk("dut1 bad", 32'(rb1), 32'(q1[0].bad));
            chk("dut1 select", 32'(sel1), 32'(q1[0].sel));
            if (out_ready) void'(q1.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rv2) begin
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut2 unexpected result idx=%0d", ri2);
         end else begin
            chk("dut2 data", 32'({r20, r21, r22}), 32'(q2[0].data));
            chk("dut2 idx", 32'(ri2), 32'(q2[0].idx));
            chk("dut2 bad", 32'(rb2), 32'(q2[0].bad));
            chk("dut2 select", 32'(sel2), 32'(q2[0].sel));
            if (out_ready) void'(q2.pop_front());
         end
      end
   end

   task automatic go(input bit which);
      @(posedge clk); #1;
      if (which) start2 = 1; else start = 1;
      @(posedge clk); #1;
      if (which) begin s_cyc2 = cyc; start2 = 0; end
      else begin s_cyc1 = cyc; start = 0; end
   endtask

   task automatic wait_done(input bit which, input int exp_cyc, input bit rnd, input bit exp_err);
      int n = 0;
      bit seen = 0;
      while (n < 400 && !seen) begin
         @(negedge clk);
         n++;
         if (which ? done2 : done1) seen = 1;
         else begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done timeout dut%0d", int'(which) + 1);
      end else begin
         if (!rnd) chk("done latency", 32'(cyc - (which ? s_cyc2 : s_cyc1)), 32'(exp_cyc));
         chk("err at done", 32'(which ? err2 : err1), 32'(exp_err));
      end
      out_ready = 1;
   endtask

   task automatic wait_res(input logic [2:0] idx);
      int n = 0;
      bit seen = 0;
      while (n < 100 && !seen) begin
         @(negedge clk);
         n++;
         seen = rv1 && ri1 == idx;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL wait for result idx=%0d timed out", idx);
      end
   endtask

   task automatic chk_reset();
      chk("rst select", 32'(sel1), 32'h3F);
      chk("rst busy", 32'(busy1), 0);
      chk("rst res_valid", 32'(rv1), 0);
      chk("rst res", 32'({r10, r11, r12}), 0);
      chk("rst res_idx", 32'(ri1), 0);
      chk("rst res_bad", 32'(rb1), 0);
      chk("rst err", 32'(err1), 0);
      chk("rst done", 32'(done1), 0);
      chk("rst select2", 32'(sel2), 32'h3F);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      logic [5:0] s;
      bit         m;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset();
      @(posedge clk); #1 rst = 0;

      // full walk with ready held high
      push_run(0, 6, 0, 6'h00);
      go(0);
      wait_done(0, 12, 0, 0);
      // start while done is high must be dropped
      start = 1;
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      chk("start during done ignored", 32'(busy1), 0);
      chk("select parked after run", 32'(sel1), 32'h3F);

      // backpressure at idx2
      push_run(0, 6, 0, 6'h00);
      go(0);
      wait_res(3'd1);
      @(posedge clk); #1 out_ready = 0;
      repeat (4) @(posedge clk);
      #1 out_ready = 1;
      wait_done(0, 15, 0, 0);
      chk("queue1 drained", 32'(q1.size()), 0);

      // manual route 3C
      mode = 1; sel_in = 6'h3C;
`ifdef PERM_MANUAL_SEL_EN
      push_run(0, 1, 1, 6'h3C);
      go(0);
      wait_done(0, 2, 0, 1);
`else
      push_run(0, 6, 0, 6'h00);
      go(0);
      wait_done(0, 12, 0, 0);
`endif
      mode = 0;

      // reset in HOLD at idx3
      push_run(0, 6, 0, 6'h00);
      go(0);
      wait_res(3'd2);
      @(posedge clk); #1 out_ready = 0;
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      q1.delete();
      @(negedge clk);
      chk_reset();
      @(negedge clk);
      chk("no done after reset", 32'(done1), 0);
      out_ready = 1;
      push_run(0, 6, 0, 6'h00);
      go(0);
      wait_done(0, 12, 0, 0);

      // NUM_PERM=2 with a second start while busy
      push_run(1, 2, 0, 6'h00);
      @(posedge clk); #1 start2 = 1;
      @(posedge clk); #1 s_cyc2 = cyc; start2 = 0;
      @(posedge clk); #1 start2 = 1;
      @(posedge clk); #1 start2 = 0;
      wait_done(1, 4, 0, 0);
      repeat (6) @(posedge clk);
      chk("queue2 drained", 32'(q2.size()), 0);
      chk("dut2 idle", 32'(busy2), 0);

      // randomized runs with random backpressure and random manual routes
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         s = 6'($urandom);
         m = 1'($urandom_range(0, 1));
         mode = m; sel_in = s;
`ifdef PERM_MANUAL_SEL_EN
         if (m) push_run(0, 1, 1, s); else push_run(0, 6, 0, 6'h00);
         go(0);
         wait_done(0, 0, 1, m && has3(s));
`else
         push_run(0, 6, 0, 6'h00);
         go(0);
         wait_done(0, 0, 1, 0);
`endif
         mode = 0;
         push_run(1, 2, 0, 6'h00);
         go(1);
         wait_done(1, 0, 1, 0);
      end
      repeat (4) @(posedge clk);
      chk("queue1 empty at end", 32'(q1.size()), 0);
      chk("queue2 empty at end", 32'(q2.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
